// File: rtl/sift_pkg.sv
// Shared constants and types for the SIFT front-end stages (blur, DoG).
package sift_pkg;

  localparam int COLS   = 640;
  localparam int PIX_W  = 8;
  localparam int ROWS   = 480;
  localparam int ADDR_W = 9;
  localparam int DOG_W  = PIX_W + 1;

  typedef logic [PIX_W-1:0]  pix_t;
  typedef logic [PIX_W:0]    dog_t;
  typedef logic [ADDR_W-1:0] row_addr_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_FIN
  } dog_state_e;

  localparam row_addr_t LAST_ROW = row_addr_t'(ROWS - 1);

endpackage

// File: rtl/dog_lane_sub.sv
// One DoG lane: signed difference of two unsigned blurred pixels.
module dog_lane_sub
  import sift_pkg::*;
(
  input  pix_t a_i,
  input  pix_t b_i,
  output dog_t d_o
);

  // One extra bit holds the full -(2^PIX_W-1)..+(2^PIX_W-1) range, so no saturation is needed.
  assign d_o = {1'b0, a_i} - {1'b0, b_i};

endmodule

// File: rtl/dog_row_builder.sv
// Difference-of-Gaussian row builder: streams blur rows A and B, writes A-B rows
// to the DoG SRAM at one row per cycle, framed by a start/done handshake.
module dog_row_builder
  import sift_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      done,
  output logic                      busy,
  output logic [ADDR_W-1:0]         blur_raddr,
  output logic                      blur_re,
  input  logic [COLS*PIX_W-1:0]     blur_dout_a,
  input  logic [COLS*PIX_W-1:0]     blur_dout_b,
  output logic                      dog_we,
  output logic [ADDR_W-1:0]         dog_addr,
  output logic [COLS*DOG_W-1:0]     dog_din
);

  dog_state_e             state_q;
  logic                   done_q;
  logic                   busy_q;
  logic                   blur_re_q;
  row_addr_t              blur_raddr_q;
  logic                   v1_q;
  row_addr_t              a1_q;
  logic                   dog_we_q;
  row_addr_t              dog_addr_q;
  logic [COLS*DOG_W-1:0]  dog_din_q;
  logic [COLS*DOG_W-1:0]  dog_row_d;

  for (genvar i = 0; i < COLS; i++) begin : g_lane
    dog_lane_sub u_lane (
      .a_i (blur_dout_a[i*PIX_W +: PIX_W]),
      .b_i (blur_dout_b[i*PIX_W +: PIX_W]),
      .d_o (dog_row_d[i*DOG_W +: DOG_W])
    );
  end

  // SRAM data for the row issued last cycle is on blur_dout_* now; v1_q/a1_q travel with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      blur_re_q    <= 1'b0;
      blur_raddr_q <= '0;
      v1_q         <= 1'b0;
      a1_q         <= '0;
      dog_we_q     <= 1'b0;
      dog_addr_q   <= '0;
      // NOTE: the wide data register is reset too because it is a visible output with a defined reset value.
      dog_din_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage read the previous cycle's value of the one before it.
      v1_q     <= blur_re_q;
      a1_q     <= blur_raddr_q;
      dog_we_q <= v1_q;
      if (v1_q) begin
        dog_addr_q <= a1_q;
        dog_din_q  <= dog_row_d;
      end
      done_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q      <= S_READ;
            busy_q       <= 1'b1;
            blur_re_q    <= 1'b1;
            blur_raddr_q <= '0;
          end
        end
        S_READ: begin
          if (blur_raddr_q == LAST_ROW) begin
            state_q   <= S_DRAIN;
            blur_re_q <= 1'b0;
          end else begin
            blur_raddr_q <= blur_raddr_q + row_addr_t'(1);
          end
        end
        S_DRAIN: begin
          // Leave only once the last write has been presented and the pipe is empty.
          if (!v1_q && !dog_we_q) begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign done       = done_q;
  assign busy       = busy_q;
  assign blur_re    = blur_re_q;
  assign blur_raddr = blur_raddr_q;
  assign dog_we     = dog_we_q;
  assign dog_addr   = dog_addr_q;
  assign dog_din    = dog_din_q;

endmodule

// File: tb/tb_dog_row_builder.sv
// Self-checking bench for dog_row_builder: SRAM model, row-level reference of A-B, pass/timing scoreboard.
module tb_dog_row_builder;
  import sift_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic                  done;
  logic                  busy;
  logic [ADDR_W-1:0]     blur_raddr;
  logic                  blur_re;
  logic [COLS*PIX_W-1:0] blur_dout_a;
  logic [COLS*PIX_W-1:0] blur_dout_b;
  logic                  dog_we;
  logic [ADDR_W-1:0]     dog_addr;
  logic [COLS*DOG_W-1:0] dog_din;

  dog_row_builder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .done        (done),
    .busy        (busy),
    .blur_raddr  (blur_raddr),
    .blur_re     (blur_re),
    .blur_dout_a (blur_dout_a),
    .blur_dout_b (blur_dout_b),
    .dog_we      (dog_we),
    .dog_addr    (dog_addr),
    .dog_din     (dog_din)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Blur SRAM images and a 1-cycle-latency read port model.
  logic [7:0] mem_a [ROWS][COLS];
  logic [7:0] mem_b [ROWS][COLS];

  always @(posedge clk) begin
    if (blur_re === 1'b1 && blur_raddr < ROWS) begin
      for (int i = 0; i < COLS; i++) begin
        blur_dout_a[i*PIX_W +: PIX_W] <= mem_a[blur_raddr][i];
        blur_dout_b[i*PIX_W +: PIX_W] <= mem_b[blur_raddr][i];
      end
    end
  end

  task automatic fill(input int mode);
    for (int r = 0; r < ROWS; r++) begin
      for (int i = 0; i < COLS; i++) begin
        case (mode)
          0:       begin mem_a[r][i] = 8'(r);          mem_b[r][i] = 8'd0;   end
          1:       begin mem_a[r][i] = 8'd0;           mem_b[r][i] = 8'd255; end
          2:       begin mem_a[r][i] = 8'd255;         mem_b[r][i] = 8'd0;   end
          3:       begin mem_a[r][i] = 8'(i);          mem_b[r][i] = 8'd1;   end
          default: begin mem_a[r][i] = 8'($urandom);   mem_b[r][i] = 8'($urandom); end
        endcase
      end
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: read-address sequence, write rows against A-B, done latency, busy framing.
  int wr_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int t0 = 0;
  int exp_row = 0;
  int rd_exp = 0;
  bit prev_re = 1'b0;
  bit prev_done = 1'b0;

  always @(negedge clk) begin : monitor
    int bad;
    int lane;
    int ref_v;
    if (rst_n !== 1'b1) begin
      exp_row   = 0;
      prev_re   = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (blur_re === 1'b1) begin
        if (!prev_re) begin
          rd_exp = 0;
          t0     = cyc;
        end
        check("raddr", blur_raddr, rd_exp);
        rd_exp++;
      end
      prev_re = (blur_re === 1'b1);

      if (dog_we === 1'b1) begin
        check("waddr", dog_addr, exp_row);
        bad = -1;
        for (int i = 0; i < COLS; i++) begin
          ref_v = (int'(mem_a[exp_row][i]) - int'(mem_b[exp_row][i])) & 511;
          if (bad < 0 && dog_din[i*DOG_W +: DOG_W] !== 9'(ref_v)) bad = i;
        end
        lane  = (bad >= 0) ? bad : int'($urandom_range(COLS - 1));
        ref_v = (int'(mem_a[exp_row][lane]) - int'(mem_b[exp_row][lane])) & 511;
        check($sformatf("lane r%0d l%0d", exp_row, lane), dog_din[lane*DOG_W +: DOG_W], ref_v);
        wr_cnt++;
        exp_row = (exp_row + 1) % ROWS;
      end

      if (prev_done) check("busy_after_done", busy, 0);
      if (done === 1'b1) begin
        check("busy_at_done", busy, 1);
        check("done_latency", cyc - t0, ROWS + 3);
        done_cnt++;
        done_cyc = cyc;
      end
      prev_done = (done === 1'b1);
    end
  end

  task automatic wait_done(input string tag, input int target);
    int n = 0;
    while (done_cnt < target && n < ROWS + 50) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, "_timeout"}, done_cnt >= target, 1);
  endtask

  task automatic run_pass(input string tag, input int restart_row);
    int w0 = wr_cnt;
    int d0 = done_cnt;
    int n  = 0;
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_re"}, blur_re, 1);
    check({tag, "_raddr0"}, blur_raddr, 0);
    while (done_cnt == d0 && n < ROWS + 50) begin
      @(negedge clk); #1;
      start = (restart_row >= 0 && blur_re === 1'b1 && int'(blur_raddr) == restart_row);
      n++;
    end
    start = 1'b0;
    check({tag, "_timeout"}, done_cnt > d0, 1);
    repeat (3) begin @(negedge clk); #1; end
    check({tag, "_writes"}, wr_cnt - w0, ROWS);
    check({tag, "_dones"}, done_cnt - d0, 1);
  endtask

  task automatic reset_mid_pass();
    int n = 0;
    int d0 = done_cnt;
    @(negedge clk); #1 start = 1'b1;
    @(negedge clk); #1 start = 1'b0;
    while (!(blur_re === 1'b1 && blur_raddr == 9'd200) && n < ROWS) begin
      @(negedge clk); #1;
      n++;
    end
    check("rst_reach_row200", blur_raddr, 200);
    rst_n = 1'b0;
    @(negedge clk); #1;
    check("rst_we", dog_we, 0);
    check("rst_re", blur_re, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_din_zero", |dog_din, 0);
    rst_n = 1'b1;
    repeat (10) begin @(negedge clk); #1; end
    check("rst_no_done", done_cnt - d0, 0);
    check("rst_idle_we", dog_we, 0);
    run_pass("after_rst", -1);
  endtask

  task automatic back_to_back();
    int w0 = wr_cnt;
    int d0 = done_cnt;
    int dc1;
    @(negedge clk); #1 start = 1'b1;
    wait_done("b2b_first", d0 + 1);
    dc1 = done_cyc;
    wait_done("b2b_second", d0 + 2);
    start = 1'b0;
    check("b2b_restart_cycle", t0 - dc1, 2);
    repeat (3) begin @(negedge clk); #1; end
    check("b2b_writes", wr_cnt - w0, 2 * ROWS);
    check("b2b_dones", done_cnt - d0, 2);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    fill(0);
    repeat (3) @(negedge clk);
    #1;
    check("reset_done", done, 0);
    check("reset_busy", busy, 0);
    check("reset_re", blur_re, 0);
    check("reset_we", dog_we, 0);
    check("reset_raddr", blur_raddr, 0);
    check("reset_waddr", dog_addr, 0);
    check("reset_din", |dog_din, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_pass("basic", -1);
    fill(1); run_pass("neg_extreme", -1);
    fill(2); run_pass("pos_extreme", -1);
    fill(3); run_pass("lane_map", -1);
    fill(4); run_pass("mid_start", 100);
    fill(4); reset_mid_pass();
    fill(4); back_to_back();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
